macs_array: RTL

//  Parametrised lane array of multiply-accumulate units for matrix-vector work mod 2^Q_BITS.
//  One scalar A is broadcast to N_LANES lanes per beat; each lane adds (+/-A)*B_i or (+/-B_i) to a running sum.
//  A multi-beat operation (first..last) starts from C_i and yields one registered result vector.

---
 rtl/macs_pkg.sv | 29 ++
 rtl/macs_lane.sv | 78 +++++++
 rtl/macs_array.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/macs_pkg.sv
// Shared definitions for the MAC lane array.
//   MODE_MATMUL / MODE_MATADD : beat term select (A*B_i or B_i)
//   state_t                   : input framing state (IDLE, OPEN)
//   mod_q()                   : keeps the low q_bits of a value and zeroes the rest
package macs_pkg;

  localparam logic MODE_MATMUL = 1'b0;
  localparam logic MODE_MATADD = 1'b1;

  // Working width of mod_q; wide enough for a full DATA_W x DATA_W product
  // up to DATA_W = 32.
  localparam int MOD_W = 64;

  typedef enum logic {
    IDLE = 1'b0,
    OPEN = 1'b1
  } state_t;

  function automatic logic [MOD_W-1:0] mod_q(input logic [MOD_W-1:0] value,
                                             input int q_bits);
    logic [MOD_W-1:0] mask;
    mask = '1;
    if (q_bits < MOD_W) begin
      mask = (MOD_W'(1) << q_bits) - MOD_W'(1);
    end
    return value & mask;
  endfunction

endpackage

// File: rtl/macs_lane.sv
// One lane of the MAC array: a beat-term register (S1) followed by the
// running accumulator and result register (S2).
// Ports:
//   clk, rstn           clock, synchronous active-low reset
//   adv                 global advance; nothing moves while low
//   load                accepted beat is loaded into S1 this cycle
//   mode, neg, a, b, c  beat operands for this lane (c only matters on first)
//   s1_valid/first/last shared S1 control bits held by the array
//   result              registered lane sum, bits at/above Q_BITS are 0
module macs_lane
  import macs_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int Q_BITS = 15
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              adv,
  input  logic              load,
  input  logic              mode,
  input  logic              neg,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] c,
  input  logic              s1_valid,
  input  logic              s1_first,
  input  logic              s1_last,
  output logic [DATA_W-1:0] result
);

  localparam int PW = 2 * DATA_W;

  logic [PW-1:0]     prod;
  logic [PW-1:0]     term_sel;
  logic [PW-1:0]     term_sgn;
  logic [DATA_W-1:0] term_nxt;

  logic [DATA_W-1:0] term_q;
  logic [DATA_W-1:0] c_q;
  logic [DATA_W-1:0] acc;

  logic [DATA_W-1:0] base;
  logic [DATA_W-1:0] sum_raw;
  logic [DATA_W-1:0] sum;

  // Full-width product; upper operand bits only reach bits that mod_q drops.
  assign prod     = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
  assign term_sel = (mode == MODE_MATADD) ? {{DATA_W{1'b0}}, b} : prod;
  assign term_sgn = neg ? (PW'(0) - term_sel) : term_sel;
  assign term_nxt = DATA_W'(mod_q(MOD_W'(term_sgn), Q_BITS));

  assign base     = s1_first ? c_q : acc;
  assign sum_raw  = base + term_q;
  assign sum      = DATA_W'(mod_q(MOD_W'(sum_raw), Q_BITS));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      term_q <= '0;
      c_q    <= '0;
    end else if (adv && load) begin
      term_q <= term_nxt;
      c_q    <= c;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      acc    <= '0;
      result <= '0;
    end else if (adv && s1_valid) begin
      acc <= sum;
      if (s1_last) begin
        result <= sum;
      end
    end
  end

endmodule

// File: rtl/macs_array.sv
// Lane array of multiply-accumulate units, arithmetic mod 2^Q_BITS.
// A scalar a is broadcast to every lane each beat; a first..last run of beats
// starts from c and produces one registered result vector.
// Ports:
//   clk, rstn                      clock, synchronous active-low reset
//   in_valid/in_ready              beat handshake (in_ready = global advance)
//   in_first/in_last               operation framing
//   mode, neg, a, b, c             beat operands (b, c packed per lane)
//   out_valid/out_ready, result    result handshake and packed lane sums
//   err, err_clr                   sticky framing error and its clear
//
// state | meaning
// IDLE  | no operation open; a beat must carry first
// OPEN  | operation in progress; beats accumulate until last
module macs_array
  import macs_pkg::*;
#(
  parameter int N_LANES = 4,
  parameter int DATA_W  = 16,
  parameter int Q_BITS  = 15
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        in_first,
  input  logic                        in_last,
  input  logic                        mode,
  input  logic                        neg,
  input  logic [DATA_W-1:0]           a,
  input  logic [N_LANES*DATA_W-1:0]   b,
  input  logic [N_LANES*DATA_W-1:0]   c,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [N_LANES*DATA_W-1:0]   result,
  output logic                        err,
  input  logic                        err_clr
);

  state_t state;
  state_t state_nxt;

  logic adv;
  logic accept;
  logic load;
  logic err_set;

  logic s1_valid;
  logic s1_first;
  logic s1_last;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign accept   = in_valid && adv;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    err_set   = 1'b0;
    if (accept) begin
      case (state)
        IDLE: begin
          if (in_first) begin
            load = 1'b1;
            if (!in_last) begin
              state_nxt = OPEN;
            end
          end else begin
            // Orphan beat: drop it rather than accumulate onto stale state.
            err_set = 1'b1;
          end
        end
        OPEN: begin
          load = 1'b1;
          // A new first abandons the open op; s1_first reloads from c.
          if (in_first) begin
            err_set = 1'b1;
          end
          if (in_last) begin
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
    end else if (adv) begin
      s1_valid <= load;
      s1_first <= in_first;
      s1_last  <= in_last;
    end
  end

  // When adv is high the held result is either absent or leaving this cycle,
  // so out_valid simply follows whether a new result lands now.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      out_valid <= 1'b0;
    end else if (adv) begin
      out_valid <= s1_valid && s1_last;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      err <= 1'b0;
    end else if (err_clr) begin
      err <= 1'b0;
    end else if (err_set) begin
      err <= 1'b1;
    end
  end

  for (genvar i = 0; i < N_LANES; i++) begin : g_lane
    macs_lane #(
      .DATA_W (DATA_W),
      .Q_BITS (Q_BITS)
    ) u_lane (
      .clk      (clk),
      .rstn     (rstn),
      .adv      (adv),
      .load     (load),
      .mode     (mode),
      .neg      (neg),
      .a        (a),
      .b        (b[i*DATA_W +: DATA_W]),
      .c        (c[i*DATA_W +: DATA_W]),
      .s1_valid (s1_valid),
      .s1_first (s1_first),
      .s1_last  (s1_last),
      .result   (result[i*DATA_W +: DATA_W])
    );
  end

endmodule
